// File: rtl/spi_slave_sync.sv
`timescale 1ns/1ps
// spi_slave_sync: SPI mode-0 slave (MSB first) with oversampled, synchronized pins,
//   a one-word TX holding buffer and a one-word RX output register.
// Latency: pin edge to internal event SYNC_STAGES+1 CLK; rx word visible 1 CLK after the last SCK rise event.
// Backpressure: TX accepts only when tx_ready (buffer empty); RX holds until rx_ready, and a word
//   completing while rx_valid is still unaccepted is dropped with an rx_overrun pulse.
//
// Ports:
//   CLK, RST (sync, active-high), ENA      - clock, reset, enable (low forces IDLE)
//   SCK, CSbar, MOSI                       - asynchronous SPI pins from the master
//   MISO, MISO_OE                          - slave data out and its output enable (1 while selected)
//   tx_data/tx_valid/tx_ready              - host write port into the TX holding buffer
//   rx_data/rx_valid/rx_ready              - received word to the host
//   rx_overrun, tx_underrun, frame_err     - single-cycle status pulses
//   busy                                   - 1 while shifting a frame
module spi_slave_sync #(
  parameter int               WIDTH         = 16,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] UNDERRUN_WORD = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic             SCK,
  input  logic             CSbar,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       shift_tx_q, shift_tx_d;
  logic [WIDTH-2:0]       shift_rx_q, shift_rx_d;
  logic [WIDTH-1:0]       tx_buf_q, tx_buf_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_overrun_q, rx_overrun_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   frame_err_q, frame_err_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic load_word;
  logic word_done;

  // Last stage of each synchronizer; edges compare it against one extra delayed sample.
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_comb begin
    state_d       = state_q;
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], CSbar};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sck_prev_d    = sck_s;
    cs_prev_d     = cs_s;
    bit_cnt_d     = bit_cnt_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;
    load_word     = 1'b0;
    word_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ENA && cs_fall) begin
          load_word  = 1'b1;
          bit_cnt_d  = '0;
          shift_rx_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (!ENA) begin
          // Partial word is dropped without a frame_err pulse.
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (cs_rise) begin
          frame_err_d = (bit_cnt_q != '0);
          state_d     = IDLE;
          bit_cnt_d   = '0;
        end else if (sck_rise) begin
          shift_rx_d = {shift_rx_q[WIDTH-3:0], mosi_s};
          if (bit_cnt_q == CW'(WIDTH-1)) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          // A fall with bit_cnt==0 follows the last rise of a word: present the next word.
          if (bit_cnt_q == '0) begin
            load_word = 1'b1;
          end else begin
            shift_tx_d = {shift_tx_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The load looks at the buffer state before any same-cycle host write, so a word
    // written in the load cycle waits for the next boundary.
    if (load_word) begin
      if (!tx_ready_q) begin
        shift_tx_d = tx_buf_q;
        tx_ready_d = 1'b1;
      end else begin
        shift_tx_d    = UNDERRUN_WORD;
        tx_underrun_d = 1'b1;
      end
    end
    if (tx_valid && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    // A word finishing in the same cycle the host accepts the old one replaces it cleanly.
    if (word_done) begin
      if (rx_valid_q && !rx_ready) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d  = {shift_rx_q, mosi_s};
        rx_valid_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      sck_sync_q    <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sck_prev_q    <= 1'b0;
      cs_prev_q     <= 1'b1;
      bit_cnt_q     <= '0;
      shift_tx_q    <= '0;
      shift_rx_q    <= '0;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sck_prev_q    <= sck_prev_d;
      cs_prev_q     <= cs_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_tx_q    <= shift_tx_d;
      shift_rx_q    <= shift_rx_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign MISO        = shift_tx_q[WIDTH-1];
  assign MISO_OE     = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT);
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
`timescale 1ns/1ps
// Directed bench for spi_slave_sync: drives SPI mode-0 frames at SCK = CLK/10 and checks
// host-side outputs and the MISO bits a master would sample on each SCK rise.
module tb_spi_slave_sync;

  logic        CLK;
  logic        RST, ENA, SCK, CSbar, MOSI;
  logic        MISO, MISO_OE;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic        rx_overrun, tx_underrun, frame_err, busy;

  spi_slave_sync #(.WIDTH(16), .SYNC_STAGES(2), .UNDERRUN_WORD(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .SCK(SCK), .CSbar(CSbar), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Event counters sampled on the falling edge, away from DUT updates.
  int          ur_cnt = 0, ov_cnt = 0, fe_cnt = 0, rx_cnt = 0;
  logic [15:0] rx_last = 16'h0;
  always @(negedge CLK) begin
    if (tx_underrun) ur_cnt++;
    if (rx_overrun)  ov_cnt++;
    if (frame_err)   fe_cnt++;
    if (rx_valid && rx_ready) begin
      rx_cnt++;
      rx_last = rx_data;
    end
  end

  logic [15:0] got_w;
  int s_ur, s_ov, s_fe, s_rx;

  task automatic clk_wait(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic tx_push(input logic [15:0] d);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 100) begin
      clk_wait(1);
      n++;
    end
    clk_wait(1);
    tx_valid = 1'b0;
    chk("tx_push_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic cs_low();
    CSbar = 1'b0;
    clk_wait(10);
  endtask

  task automatic cs_high();
    CSbar = 1'b1;
    clk_wait(10);
  endtask

  task automatic sck_low();
    SCK = 1'b0;
    clk_wait(5);
  endtask

  // Bits [from,to) of w, MSB first; SCK falls at the start of each bit and the
  // master samples MISO right after raising SCK. Leaves SCK high.
  task automatic bits(input logic [15:0] w, input int from, input int to);
    for (int i = from; i < to; i++) begin
      SCK  = 1'b0;
      MOSI = w[15-i];
      clk_wait(5);
      SCK   = 1'b1;
      got_w = {got_w[14:0], MISO};
      clk_wait(5);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; ENA = 1'b1; SCK = 1'b0; CSbar = 1'b1; MOSI = 1'b0;
    tx_data = 16'h0; tx_valid = 1'b0; rx_ready = 1'b0; got_w = 16'h0;
    clk_wait(3);
    chk("rst_miso",     32'(MISO),     32'd0);
    chk("rst_miso_oe",  32'(MISO_OE),  32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  32'(rx_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    RST = 1'b0;
    clk_wait(5);

    // 1: preloaded ABCD out, 1234 in
    tx_push(16'hABCD);
    chk("t1_tx_full", 32'(tx_ready), 32'd0);
    cs_low();
    chk("t1_miso_oe", 32'(MISO_OE), 32'd1);
    chk("t1_busy",    32'(busy),    32'd1);
    got_w = 16'h0;
    bits(16'h1234, 0, 16);
    sck_low();
    cs_high();
    chk("t1_miso_word", 32'(got_w),    32'hABCD);
    chk("t1_rx_valid",  32'(rx_valid), 32'd1);
    chk("t1_rx_data",   32'(rx_data),  32'h1234);
    chk("t1_tx_ready",  32'(tx_ready), 32'd1);
    chk("t1_idle_oe",   32'(MISO_OE),  32'd0);
    rx_ready = 1'b1;
    clk_wait(2);
    chk("t1_rx_clear",  32'(rx_valid), 32'd0);

    // 2: two words in one frame, second TX word written mid-word 1
    tx_push(16'hABCD);
    s_ur = ur_cnt; s_ov = ov_cnt; s_fe = fe_cnt; s_rx = rx_cnt;
    cs_low();
    got_w = 16'h0;
    bits(16'h00FF, 0, 8);
    tx_push(16'h5A5A);
    bits(16'h00FF, 8, 16);
    chk("t2_miso_w1", 32'(got_w),   32'hABCD);
    chk("t2_rx_w1",   32'(rx_last), 32'h00FF);
    got_w = 16'h0;
    bits(16'hFF00, 0, 16);
    chk("t2_miso_w2", 32'(got_w),   32'h5A5A);
    chk("t2_rx_w2",   32'(rx_last), 32'hFF00);
    chk("t2_rx_cnt",  32'(rx_cnt - s_rx), 32'd2);
    chk("t2_no_ur",   32'(ur_cnt - s_ur), 32'd0);
    chk("t2_no_ov",   32'(ov_cnt - s_ov), 32'd0);
    chk("t2_no_fe",   32'(fe_cnt - s_fe), 32'd0);
    sck_low();
    cs_high();

    // 3: empty TX buffer at frame start
    chk("t3_tx_empty", 32'(tx_ready), 32'd1);
    s_ur = ur_cnt;
    cs_low();
    chk("t3_underrun", 32'(ur_cnt - s_ur), 32'd1);
    got_w = 16'hFFFF;
    bits(16'hC3C3, 0, 16);
    chk("t3_miso_zero", 32'(got_w),   32'h0000);
    chk("t3_rx",        32'(rx_last), 32'hC3C3);
    sck_low();
    cs_high();

    // 4: partial frame of 7 bits, then a good frame
    s_fe = fe_cnt; s_rx = rx_cnt;
    cs_low();
    bits(16'hFFFF, 0, 7);
    sck_low();
    cs_high();
    chk("t4_frame_err", 32'(fe_cnt - s_fe), 32'd1);
    chk("t4_no_rx",     32'(rx_cnt - s_rx), 32'd0);
    tx_push(16'h9696);
    cs_low();
    got_w = 16'h0;
    bits(16'hBEEF, 0, 16);
    chk("t4_miso", 32'(got_w),   32'h9696);
    chk("t4_rx",   32'(rx_last), 32'hBEEF);
    sck_low();
    cs_high();

    // 5: host stalls, second word overruns
    rx_ready = 1'b0;
    s_ov = ov_cnt;
    cs_low();
    bits(16'h1111, 0, 16);
    bits(16'h2222, 0, 16);
    sck_low();
    cs_high();
    chk("t5_overrun", 32'(ov_cnt - s_ov), 32'd1);
    chk("t5_rx_valid", 32'(rx_valid), 32'd1);
    chk("t5_rx_data",  32'(rx_data),  32'h1111);
    rx_ready = 1'b1;
    clk_wait(2);
    chk("t5_rx_clear", 32'(rx_valid), 32'd0);

    // 6: reset mid-frame, then a frame with ENA low
    cs_low();
    tx_push(16'h7777);
    chk("t6_tx_full", 32'(tx_ready), 32'd0);
    bits(16'hA5A5, 0, 9);
    RST = 1'b1; SCK = 1'b0; CSbar = 1'b1;
    clk_wait(1);
    chk("t6_rst_miso",     32'(MISO),     32'd0);
    chk("t6_rst_miso_oe",  32'(MISO_OE),  32'd0);
    chk("t6_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("t6_rst_rx_data",  32'(rx_data),  32'd0);
    chk("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("t6_rst_busy",     32'(busy),     32'd0);
    clk_wait(4);
    RST = 1'b0;
    clk_wait(5);
    ENA = 1'b0;
    s_rx = rx_cnt;
    cs_low();
    chk("t6_dis_oe",   32'(MISO_OE), 32'd0);
    chk("t6_dis_busy", 32'(busy),    32'd0);
    bits(16'h3C3C, 0, 16);
    sck_low();
    cs_high();
    chk("t6_dis_no_rx", 32'(rx_cnt - s_rx), 32'd0);
    ENA = 1'b1;
    clk_wait(2);
    cs_low();
    bits(16'h0F0F, 0, 16);
    sck_low();
    cs_high();
    chk("t6_reenable_rx", 32'(rx_last), 32'h0F0F);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
